// File: rtl/channel_scan_mux_pkg.sv
// Shared types, mode encodings and the channel-slice helper for the scanning channel mux.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Helper bounds: packed bus up to MAX_BUS bits, words up to MAX_WIDTH bits.
  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_BUS   = 1024;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Word idx of a packed bus, LSB-aligned; caller truncates to its own width.
  function automatic logic [MAX_WIDTH-1:0] chan_word(input logic [MAX_BUS-1:0] bus,
                                                     input int unsigned idx,
                                                     input int unsigned width);
    logic [MAX_BUS-1:0] shifted;
    shifted = bus >> (idx * width);
    return shifted[MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/channel_scan_mux_if.sv
// Channel inputs and registered output handshake of the scanning channel mux.
interface channel_scan_mux_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_BITS = $clog2(CHANNELS);

  logic                      mode;
  logic [SEL_BITS-1:0]       address;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_BITS-1:0]       out_channel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output mode, address, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_channel, out_valid
  );

  modport slave (
    input  mode, address, in_data, in_valid, out_ready,
    output in_ready, out_data, out_channel, out_valid
  );
endinterface

// File: rtl/channel_scan_mux_rr_pick.sv
// Round-robin pick: first valid channel at or after the pointer (rotate, priority-encode, un-rotate).
module channel_rr_pick #(
  parameter int unsigned CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]         i_valid,
  input  logic [$clog2(CHANNELS)-1:0] i_ptr,
  output logic                        o_found,
  output logic [$clog2(CHANNELS)-1:0] o_index
);
  localparam int unsigned SEL_BITS = $clog2(CHANNELS);

  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_rot;
  logic [SEL_BITS-1:0]   w_off;

  assign w_dbl = {i_valid, i_valid} >> i_ptr;
  assign w_rot = w_dbl[CHANNELS-1:0];

  // Lowest set bit of the rotated vector is the distance from the pointer.
  always_comb begin
    w_off = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = SEL_BITS'(k);
    end
  end

  assign o_found = |i_valid;
  assign o_index = SEL_BITS'(i_ptr + w_off);
endmodule

// File: rtl/channel_scan_mux.sv
// Registered N:1 channel mux with manual or round-robin selection and a stallable one-entry output.
module channel_scan_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input logic               clk,
  input logic               reset,
  channel_scan_mux_if.slave bus
);
  localparam int unsigned SEL_BITS = $clog2(CHANNELS);

  state_e              r_state;
  state_e              w_state_next;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_BITS-1:0] r_channel;
  logic [SEL_BITS-1:0] r_ptr;

  logic                w_rr_found;
  logic [SEL_BITS-1:0] w_rr_index;
  logic [SEL_BITS-1:0] w_chosen;
  logic                w_eligible;
  logic                w_load;
  logic [CHANNELS-1:0] w_ready;
  logic [WIDTH-1:0]    w_word;

  channel_rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .i_valid (bus.in_valid),
    .i_ptr   (r_ptr),
    .o_found (w_rr_found),
    .o_index (w_rr_index)
  );

  // Next state, load decision and the one-hot acknowledge.
  always_comb begin
    w_state_next = r_state;
    w_chosen     = bus.address;
    w_eligible   = bus.in_valid[bus.address];
    w_load       = 1'b0;
    w_ready      = '0;

    if (bus.mode == MODE_SCAN) begin
      w_chosen   = w_rr_index;
      w_eligible = w_rr_found;
    end

    w_load = ((r_state == ST_EMPTY) || bus.out_ready) && w_eligible && !reset;
    if (w_load) w_ready = CHANNELS'(1) << w_chosen;

    case (r_state)
      ST_EMPTY: if (w_load) w_state_next = ST_FULL;
      ST_FULL:  if (bus.out_ready && !w_load) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  assign w_word = WIDTH'(chan_word(MAX_BUS'(bus.in_data), 32'(w_chosen), WIDTH));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_next;
  end

  // Output word and scan pointer; the pointer moves only on scan-mode loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_channel <= '0;
      r_ptr     <= '0;
    end else if (w_load) begin
      r_data    <= w_word;
      r_channel <= w_chosen;
      if (bus.mode == MODE_SCAN) r_ptr <= SEL_BITS'(w_chosen + SEL_BITS'(1));
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_data    = r_data;
  assign bus.out_channel = r_channel;
  assign bus.out_valid   = (r_state == ST_FULL);
endmodule

// File: tb/tb_channel_scan_mux.sv
// Directed bench for channel_scan_mux at WIDTH=8, CHANNELS=4.
module tb_channel_scan_mux;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  channel_scan_mux_if #(.WIDTH(8), .CHANNELS(4)) bus ();

  channel_scan_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [1:0] a, input logic [3:0] v, input logic r);
    @(negedge clk);
    bus.mode      = m;
    bus.address   = a;
    bus.in_valid  = v;
    bus.out_ready = r;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_in_ready got=%b want=0000", bus.in_ready);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_channel !== 2'd0) begin
      bad++; $display("FAIL reset_outputs got v=%b d=%h c=%0d want v=0 d=00 c=0",
                      bus.out_valid, bus.out_data, bus.out_channel);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_manual_sweep();
    logic [7:0] exp_d [4];
    logic [3:0] exp_r [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.in_data = 32'h44332211;
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 2'(a), 4'hF, 1'b1);
      total++;
      if (bus.in_ready !== exp_r[a]) begin
        bad++; $display("FAIL manual_ready[%0d] got=%b want=%b", a, bus.in_ready, exp_r[a]);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[a] || bus.out_channel !== 2'(a)) begin
        bad++; $display("FAIL manual_out[%0d] got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                        a, bus.out_valid, bus.out_data, bus.out_channel, exp_d[a], a);
      end
    end
  endtask

  task automatic test_scan_fairness();
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd0, 4'hF, 1'b1);
      tick();
      total++;
      if (bus.out_channel !== 2'(i % 4) || bus.out_data !== exp_d[i % 4] || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL fair[%0d] got c=%0d d=%h v=%b want c=%0d d=%h v=1",
                        i, bus.out_channel, bus.out_data, bus.out_valid, i % 4, exp_d[i % 4]);
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0] vld [4];
    logic [1:0] exp_c [4];
    logic [3:0] exp_r [4];
    vld   = '{4'b0001, 4'b1001, 4'b1001, 4'b1001};
    exp_c = '{2'd0, 2'd3, 2'd0, 2'd3};
    exp_r = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, vld[i], 1'b1);
      total++;
      if (bus.in_ready !== exp_r[i]) begin
        bad++; $display("FAIL skip_ready[%0d] got=%b want=%b", i, bus.in_ready, exp_r[i]);
      end
      tick();
      total++;
      if (bus.out_channel !== exp_c[i]) begin
        bad++; $display("FAIL skip_chan[%0d] got=%0d want=%0d", i, bus.out_channel, exp_c[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] addrs [3];
    logic [3:0] vlds  [3];
    addrs = '{2'd2, 2'd3, 2'd0};
    vlds  = '{4'b1111, 4'b0101, 4'b1010};
    bus.in_data = 32'h44332211;
    drive(1'b0, 2'd1, 4'hF, 1'b1);
    tick();
    total++;
    if (bus.out_data !== 8'h22 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_load got d=%h v=%b want d=22 v=1", bus.out_data, bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(logic'(i == 1), addrs[i], vlds[i], 1'b0);
      bus.in_data = 32'hDDCCBBAA;
      #1;
      total++;
      if (bus.in_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_ready[%0d] got=%b want=0000", i, bus.in_ready);
      end
      tick();
      total++;
      if (bus.out_data !== 8'h22 || bus.out_channel !== 2'd1 || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got d=%h c=%0d v=%b want d=22 c=1 v=1",
                        i, bus.out_data, bus.out_channel, bus.out_valid);
      end
    end
    drive(1'b0, 2'd2, 4'hF, 1'b1);
    total++;
    if (bus.in_ready !== 4'b0100) begin
      bad++; $display("FAIL bp_release_ready got=%b want=0100", bus.in_ready);
    end
    tick();
    total++;
    if (bus.out_data !== 8'hCC || bus.out_channel !== 2'd2 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release_out got d=%h c=%0d v=%b want d=cc c=2 v=1",
                      bus.out_data, bus.out_channel, bus.out_valid);
    end
  endtask

  task automatic test_drain();
    bus.in_data = 32'h44332211;
    drive(1'b1, 2'd0, 4'b0100, 1'b1);
    tick();
    total++;
    if (bus.out_channel !== 2'd2 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL drain_setup got c=%0d v=%b want c=2 v=1", bus.out_channel, bus.out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 4'b0000, 1'b1);
      total++;
      if (bus.in_ready !== 4'b0000) begin
        bad++; $display("FAIL drain_ready[%0d] got=%b want=0000", i, bus.in_ready);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL drain_valid[%0d] got=%b want=0", i, bus.out_valid);
      end
    end
    drive(1'b1, 2'd0, 4'hF, 1'b1);
    tick();
    total++;
    if (bus.out_channel !== 2'd3 || bus.out_data !== 8'h44 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL drain_ptr got c=%0d d=%h v=%b want c=3 d=44 v=1",
                      bus.out_channel, bus.out_data, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 2'd0, 4'b0010, 1'b1);
    tick();
    drive(1'b1, 2'd0, 4'hF, 1'b0);
    total++;
    if (bus.out_channel !== 2'd1 || bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000) begin
      bad++; $display("FAIL rst_stall_setup got c=%0d v=%b r=%b want c=1 v=1 r=0000",
                      bus.out_channel, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 4'b0000) begin
      bad++; $display("FAIL rst_stall_ready got=%b want=0000", bus.in_ready);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_channel !== 2'd0) begin
      bad++; $display("FAIL rst_stall_out got v=%b d=%h c=%0d want v=0 d=00 c=0",
                      bus.out_valid, bus.out_data, bus.out_channel);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 2'd0, 4'b1110, 1'b1);
    total++;
    if (bus.in_ready !== 4'b0010) begin
      bad++; $display("FAIL rst_first_ready got=%b want=0010", bus.in_ready);
    end
    tick();
    total++;
    if (bus.out_channel !== 2'd1 || bus.out_data !== 8'h22 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL rst_first_grant got c=%0d d=%h v=%b want c=1 d=22 v=1",
                      bus.out_channel, bus.out_data, bus.out_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.mode      = 1'b0;
    bus.address   = 2'd0;
    bus.in_data   = 32'h0;
    bus.in_valid  = 4'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_manual_sweep();
    test_scan_fairness();
    test_skip_wrap();
    test_backpressure();
    test_drain();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/channel_scan_mux.md
# channel_scan_mux

Registered, parametrised N:1 channel multiplexer with valid/ready handshaking on every channel and on the output. It selects one of `CHANNELS` input words either by an explicit address (manual mode) or by a round-robin scan over channels presenting valid data (scan mode). It holds the selected word in a one-entry output register, which backpressure can stall. It succeeds the 4:1 combinational selector in the datapath wherever sources are bursty and the consumer can stall.

## Interface
- `WIDTH`, 8, data bits per channel (≥1)
- `CHANNELS`, 4, number of inputs; power of two, ≥2
- `SEL_BITS`, derived localparam = $clog2(CHANNELS)

One clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = manual (use `address`), 1 = round-robin scan
- `address`  in  SEL_BITS  channel select in manual mode
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  CHANNELS  per-channel data valid
- `in_ready`  out  CHANNELS  one-hot; bit i high in the cycle channel i's word is captured
- `out_data`  out  WIDTH  registered selected word
- `out_channel`  out  SEL_BITS  index the held word came from
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  consumer accepts `out_data` this cycle

## Operation
- **Register states:**
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- **Load condition:** load = (EMPTY or `out_ready`) and the chosen channel is eligible.
- **Channel choice:**
  - Manual mode: chosen = `address`. Eligible iff `in_valid[address]`.
  - Scan mode: chosen = first i with `in_valid[i]`, searching pointer, pointer+1, … mod CHANNELS. Eligible iff any `in_valid`.
- **On load:**
  - `out_data` ← chosen word; `out_channel` ← chosen; `out_valid` ← 1.
  - `in_ready[chosen]`=1 in the same cycle (combinational).
- **No load with FULL and `out_ready`:** `out_valid` ← 0 (drain).
- **FULL and not `out_ready`:**
  - `out_data`, `out_channel` and `out_valid` hold.
  - All `in_ready`=0.
- **Pointer:**
  - Updates only on a scan-mode load: pointer ← (chosen+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - Manual-mode loads leave the pointer unchanged.
- **Fairness:** with all channels continuously valid and `out_ready`=1, scan mode grants 0,1,2,…,CHANNELS-1,0,…

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_channel`=0, pointer=0.
  - `in_ready`=0 while `reset` is high.
- **Reset mid-operation:**
  - The held word is dropped without handshake.
  - No input is acknowledged in the reset cycle.
- **Latency:** captured at edge k, `out_valid`=1 visible after edge k. One cycle from `in_valid`&`in_ready` to `out_valid`.
- **Throughput:** one word per cycle when `out_ready` is held high. Simultaneous drain and load in the same cycle is allowed, with no bubble.
- **Combinational paths:**
  - `in_ready` depends on `in_valid`, `mode`, `address`, `out_ready` and state.
  - No combinational path from `in_data` to any output.
- **Changes while stalled:** a `mode` or `address` change while FULL and stalled has no effect on the held word. It applies to the next load.
- **Empty inputs:** with no valid inputs, `out_valid` falls after the drain and the pointer is unchanged.

## Structure
- Package `mux_pkg`:
  - `MODE_MANUAL`=1'b0, `MODE_SCAN`=1'b1.
  - Channel-slice helper function for extracting word i from the packed bus.
- Sub-module `channel_rr_pick`, purely combinational:
  - Inputs: `in_valid`, pointer.
  - Outputs: `found` and the index of the first valid channel at or after the pointer (rotate, priority-encode, un-rotate).
- Top level holds the output register, pointer register, mode mux and `in_ready` decode.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4.
- Manual sweep: in_data={8'h44,8'h33,8'h22,8'h11}, all valid, `out_ready`=1, address 0,1,2,3 → `out_data` 11,22,33,44 one cycle later; `in_ready` one-hot 0001,0010,0100,1000.
- Scan fairness: all valid, mode=1, `out_ready`=1 for 8 cycles → `out_channel` 0,1,2,3,0,1,2,3.
- Skip and wrap: scan, `in_valid`=4'b1001, pointer=1 → grant 3, then 0, then 3; pointer wraps 0→1→0.
- Backpressure: FULL with 8'h22, `out_ready`=0 for 3 cycles while inputs and address change → `out_data` stays 8'h22, `in_ready`=0000; on `out_ready`=1 the new word loads the same cycle.
- Drain to empty: FULL, `in_valid`=0, `out_ready`=1 → `out_valid`=0 next cycle, pointer unchanged.
- Reset mid-stall: FULL and stalled, `reset` pulsed 1 cycle → `out_valid`=0, `out_data`=0, `out_channel`=0, pointer=0; first scan grant after reset is the lowest valid channel.
